// File: rtl/seg7_to_bcd_decoder_if.sv
// Display-side lines snooped by the decoder plus the recovered-digit outputs.
interface seg7_to_bcd_decoder_if;
    logic [6:0] Segments;
    logic       dp;
    logic       SEL7;
    logic [3:0] digit;
    logic       dp_out;
    logic       digit_valid;
    logic       blank;
    logic       seg_error;

    modport master (
        output Segments, dp, SEL7,
        input  digit, dp_out, digit_valid, blank, seg_error
    );

    modport slave (
        input  Segments, dp, SEL7,
        output digit, dp_out, digit_valid, blank, seg_error
    );
endinterface

// File: rtl/seg7_to_bcd_decoder.sv
// Recovers the BCD/hex digit shown on an active-low 7-segment display once its
// pattern has been stable for STABLE_CYCLES clocks.
module seg7_to_bcd_decoder #(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter bit          HEX_EN        = 1'b0
) (
    input  logic                  clk50MHz,
    input  logic                  rst,
    seg7_to_bcd_decoder_if.slave  bus
);
    localparam logic [7:0] ACC_CNT = 8'(STABLE_CYCLES - 1);
    localparam logic [7:0] SAT_CNT = 8'(STABLE_CYCLES);

    // State bits double as the blank/seg_error outputs.
    typedef enum logic [1:0] {
        CLS_DIGIT = 2'b00,
        CLS_BLANK = 2'b01,
        CLS_ERROR = 2'b10
    } cls_t;

    logic [8:0] sync1, sync2;
    logic [7:0] pat;
    logic [7:0] last;
    logic [7:0] cnt;
    logic [6:0] s;
    logic       accept;
    logic       dec_ok;
    logic       dec_blank;
    logic [3:0] dec_val;
    cls_t       cls_q;
    logic [3:0] digit_q;
    logic       dp_q;
    logic       valid_q;

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {bus.SEL7, bus.dp, bus.Segments};
            sync2 <= sync1;
        end
    end

    always_comb begin
        pat       = sync2[8] ? 8'hFF : sync2[7:0];
        s         = ~pat[6:0];
        accept    = (pat == last) && (cnt == ACC_CNT);
        dec_blank = (s == '0);
        dec_ok    = 1'b0;
        dec_val   = '0;
        case (s)
            7'h3F: begin dec_ok = 1'b1;   dec_val = 4'h0; end
            7'h06: begin dec_ok = 1'b1;   dec_val = 4'h1; end
            7'h5B: begin dec_ok = 1'b1;   dec_val = 4'h2; end
            7'h4F: begin dec_ok = 1'b1;   dec_val = 4'h3; end
            7'h66: begin dec_ok = 1'b1;   dec_val = 4'h4; end
            7'h6D: begin dec_ok = 1'b1;   dec_val = 4'h5; end
            7'h7D: begin dec_ok = 1'b1;   dec_val = 4'h6; end
            7'h07: begin dec_ok = 1'b1;   dec_val = 4'h7; end
            7'h7F: begin dec_ok = 1'b1;   dec_val = 4'h8; end
            7'h6F: begin dec_ok = 1'b1;   dec_val = 4'h9; end
            7'h77: begin dec_ok = HEX_EN; dec_val = 4'hA; end
            7'h7C: begin dec_ok = HEX_EN; dec_val = 4'hB; end
            7'h39: begin dec_ok = HEX_EN; dec_val = 4'hC; end
            7'h5E: begin dec_ok = HEX_EN; dec_val = 4'hD; end
            7'h79: begin dec_ok = HEX_EN; dec_val = 4'hE; end
            7'h71: begin dec_ok = HEX_EN; dec_val = 4'hF; end
            default: begin dec_ok = 1'b0; dec_val = '0; end
        endcase
    end

    always_ff @(posedge clk50MHz or posedge rst) begin
        if (rst) begin
            last    <= 8'hFF;
            cnt     <= '0;
            cls_q   <= CLS_BLANK;
            digit_q <= '0;
            dp_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (pat != last) begin
                last <= pat;
                cnt  <= '0;
            end else if (cnt != SAT_CNT) begin
                cnt <= cnt + 8'd1;
            end
            // Counter saturates past ACC_CNT, so a held pattern is accepted once.
            if (accept) begin
                if (dec_blank) begin
                    cls_q <= CLS_BLANK;
                end else if (dec_ok) begin
                    cls_q   <= CLS_DIGIT;
                    digit_q <= dec_val;
                    dp_q    <= ~pat[7];
                    valid_q <= 1'b1;
                end else begin
                    cls_q <= CLS_ERROR;
                end
            end
        end
    end

    assign bus.digit       = digit_q;
    assign bus.dp_out      = dp_q;
    assign bus.digit_valid = valid_q;
    assign bus.blank       = cls_q[0];
    assign bus.seg_error   = cls_q[1];
endmodule
